// File: rtl/sw_s_stream_packer_if.sv
// ---------------------------------------------------------------------------
// sw_s_stream_packer_if
// Bundles the symbol-stream input side and the array-facing output side of
// the S-sequence packer.
//   master : the producer/array side (drives i_*, observes o_*)
//   slave  : the packer itself (observes i_*, drives o_*)
// Signals:
//   i_clear      synchronous clear of accumulator and FIFO
//   i_sym        2*SYM_IN symbol bits, symbol k at [2k+1:2k]
//   i_sym_cnt    valid symbols in a last beat (1..SYM_IN)
//   i_last       beat closes the current S sequence
//   i_sym_valid  beat offered
//   o_sym_ready  packer can take a beat this cycle
//   i_request_s  array asks for one packed word
//   o_s          packed word (PE_NUM symbols)
//   o_s_cnt      valid symbols in o_s, 0 = no data
//   o_s_last     o_s closes a sequence
//   o_fifo_cnt   words currently buffered
//   o_empty      FIFO and accumulator both empty
// ---------------------------------------------------------------------------
interface sw_s_stream_packer_if #(
   parameter int PE_NUM = 64,
   parameter int SYM_IN = 8,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 7
);
   localparam int SC_W = $clog2(SYM_IN) + 1;
   localparam int FC_W = $clog2(DEPTH) + 1;

   logic                  i_clear;
   logic [2*SYM_IN-1:0]   i_sym;
   logic [SC_W-1:0]       i_sym_cnt;
   logic                  i_last;
   logic                  i_sym_valid;
   logic                  o_sym_ready;
   logic                  i_request_s;
   logic [2*PE_NUM-1:0]   o_s;
   logic [CNT_W-1:0]      o_s_cnt;
   logic                  o_s_last;
   logic [FC_W-1:0]       o_fifo_cnt;
   logic                  o_empty;

   modport master (
      output i_clear, i_sym, i_sym_cnt, i_last, i_sym_valid, i_request_s,
      input  o_sym_ready, o_s, o_s_cnt, o_s_last, o_fifo_cnt, o_empty
   );

   modport slave (
      input  i_clear, i_sym, i_sym_cnt, i_last, i_sym_valid, i_request_s,
      output o_sym_ready, o_s, o_s_cnt, o_s_last, o_fifo_cnt, o_empty
   );
endinterface

// File: rtl/sw_s_stream_packer.sv
// ---------------------------------------------------------------------------
// sw_s_stream_packer
// Packs a narrow 2-bit-per-nucleotide symbol stream LSB-first into
// PE_NUM-symbol words, buffers them in a DEPTH-word FIFO and serves one word
// per i_request_s pulse with one cycle of latency.
// Ports:
//   clk  clock, all state on the rising edge
//   rst  asynchronous active-high reset
//   bus  sw_s_stream_packer_if.slave (stream input, array output, status)
// ---------------------------------------------------------------------------
module sw_s_stream_packer #(
   parameter int PE_NUM = 64,
   parameter int SYM_IN = 8,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   sw_s_stream_packer_if.slave  bus
);
   localparam int W    = 2 * PE_NUM;
   localparam int AW   = $clog2(DEPTH);
   localparam int FC_W = $clog2(DEPTH) + 1;

   // accumulator and fill pointer (in symbols)
   logic [W-1:0]      acc_q, acc_d;
   logic [CNT_W-1:0]  p_q, p_d;

   // FIFO bookkeeping
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [FC_W-1:0]   cnt_q, cnt_d;

   // registered output word
   logic [W-1:0]      o_s_q, o_s_d;
   logic [CNT_W-1:0]  o_s_cnt_q, o_s_cnt_d;
   logic              o_s_last_q, o_s_last_d;

   // FIFO storage
   logic [W-1:0]      mem_word [DEPTH];
   logic [CNT_W-1:0]  mem_cnt  [DEPTH];
   logic              mem_last [DEPTH];

   logic                ready;
   logic                accept;
   logic                push;
   logic                pop;
   logic [CNT_W-1:0]    n;
   logic [CNT_W-1:0]    fill;
   logic [2*SYM_IN-1:0] beat;
   logic [W-1:0]        merged;

   assign ready  = (cnt_q < FC_W'(DEPTH)) & ~bus.i_clear;
   assign accept = bus.i_sym_valid & ready;
   // non-last beats are always full, whatever i_sym_cnt says
   assign n      = bus.i_last ? CNT_W'(bus.i_sym_cnt) : CNT_W'(SYM_IN);
   assign fill   = p_q + n;

   // zero the symbols beyond n so unused word positions stay 0
   genvar gi;
   generate
      for (gi = 0; gi < SYM_IN; gi++) begin : g_mask
         assign beat[2*gi +: 2] = (CNT_W'(gi) < n) ? bus.i_sym[2*gi +: 2] : 2'b00;
      end
   endgenerate

   // p is a multiple of SYM_IN, so the beat lands in an all-zero slot
   assign merged = acc_q | (W'(beat) << {p_q, 1'b0});

   // a word commits when it is full or the sequence ends
   assign push = accept & ((fill == CNT_W'(PE_NUM)) | bus.i_last);
   assign pop  = bus.i_request_s & (cnt_q != '0) & ~bus.i_clear;

   always_comb begin
      acc_d      = acc_q;
      p_d        = p_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      o_s_d      = '0;
      o_s_cnt_d  = '0;
      o_s_last_d = 1'b0;
      if (bus.i_clear) begin
         acc_d    = '0;
         p_d      = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) begin
            acc_d    = '0;
            p_d      = '0;
            wr_ptr_d = wr_ptr_q + 1'b1;
         end else if (accept) begin
            acc_d = merged;
            p_d   = fill;
         end
         // a word pushed this cycle is not visible to a coincident request
         if (pop) begin
            o_s_d      = mem_word[rd_ptr_q];
            o_s_cnt_d  = mem_cnt[rd_ptr_q];
            o_s_last_d = mem_last[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + 1'b1;
         end
         cnt_d = cnt_q + FC_W'(push) - FC_W'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q      <= '0;
         p_q        <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         o_s_q      <= '0;
         o_s_cnt_q  <= '0;
         o_s_last_q <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         p_q        <= p_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         o_s_q      <= o_s_d;
         o_s_cnt_q  <= o_s_cnt_d;
         o_s_last_q <= o_s_last_d;
      end
   end

   // storage needs no reset: occupancy is tracked by the pointers
   always_ff @(posedge clk) begin
      if (push) begin
         mem_word[wr_ptr_q] <= merged;
         mem_cnt[wr_ptr_q]  <= fill;
         mem_last[wr_ptr_q] <= bus.i_last;
      end
   end

   assign bus.o_sym_ready = ready;
   assign bus.o_s         = o_s_q;
   assign bus.o_s_cnt     = o_s_cnt_q;
   assign bus.o_s_last    = o_s_last_q;
   assign bus.o_fifo_cnt  = cnt_q;
   assign bus.o_empty     = (cnt_q == '0) & (p_q == '0);
endmodule
